// File: rtl/code_converter_pkg.sv
// Shared mode encodings, code-range constants and the converter result payload for code_converter.
package code_converter_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned MODE_W   = 2;

    localparam logic [MODE_W-1:0] MODE_BIN2GRAY = 2'b00;
    localparam logic [MODE_W-1:0] MODE_GRAY2BIN = 2'b01;
    localparam logic [MODE_W-1:0] MODE_BCD2XS3  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_XS32BCD  = 2'b11;

    localparam logic [NIBBLE_W-1:0] XS3_OFFSET = 4'd3;
    localparam logic [NIBBLE_W-1:0] BCD_MAX    = 4'd9;
    localparam logic [NIBBLE_W-1:0] XS3_MIN    = 4'd3;
    localparam logic [NIBBLE_W-1:0] XS3_MAX    = 4'd12;

    typedef struct packed {
        logic [NIBBLE_W-1:0] y;
        logic                err;
    } conv_result_t;

endpackage

// File: rtl/code_converter_core.sv
// Combinational nibble translation: (x, mode) -> converted code and illegal-input flag.
module code_converter_core
    import code_converter_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [MODE_W-1:0]   mode,
    output conv_result_t        res_c
);

    always_comb begin
        res_c = '0;
        case (mode)
            MODE_BIN2GRAY: res_c.y = x ^ (x >> 1);
            // Each binary bit is the XOR of all Gray bits at or above it.
            MODE_GRAY2BIN: res_c.y = {x[3], ^x[3:2], ^x[3:1], ^x[3:0]};
            MODE_BCD2XS3: begin
                if (x <= BCD_MAX) begin
                    res_c.y = x + XS3_OFFSET;
                end else begin
                    res_c.err = 1'b1;
                end
            end
            default: begin
                if ((x >= XS3_MIN) && (x <= XS3_MAX)) begin
                    res_c.y = x - XS3_OFFSET;
                end else begin
                    res_c.err = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/code_converter.sv
// Registered 4-bit code converter (Gray / XS3) with valid and error flags.
// Optional odd-parity output enabled by defining CODE_CONVERTER_PARITY_EN.
module code_converter
    import code_converter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [MODE_W-1:0] mode,
    input  logic              a,
    input  logic              b,
    input  logic              c,
    input  logic              d,
    output logic              e,
    output logic              f,
    output logic              g,
    output logic              h,
    output logic              out_valid,
    output logic              err
`ifdef CODE_CONVERTER_PARITY_EN
    ,
    output logic              parity
`endif
);

    conv_result_t        res_c;
    logic [NIBBLE_W-1:0] y_q;
    logic                err_q;
    logic                out_valid_q;

    code_converter_core u_core (
        .x     ({a, b, c, d}),
        .mode  (mode),
        .res_c (res_c)
    );

    // Result and error hold while idle; valid is a one-cycle strobe per accepted input.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                y_q   <= res_c.y;
                err_q <= res_c.err;
            end
        end
    end

`ifdef CODE_CONVERTER_PARITY_EN
    logic parity_q;

    // Odd parity over the result, so {y, parity} always carries an odd number of ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b1;
        end else if (in_valid) begin
            parity_q <= ~(^res_c.y);
        end
    end

    assign parity = parity_q;
`endif

    assign {e, f, g, h} = y_q;
    assign out_valid    = out_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_code_converter.sv
// Self-checking bench for code_converter: directed spec cases plus random traffic against a behavioural model.
module tb_code_converter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] mode;
    logic       a, b, c, d;
    logic       e, f, g, h;
    logic       out_valid;
    logic       err;
`ifdef CODE_CONVERTER_PARITY_EN
    logic       parity;
`endif

    int errors = 0;
    int checks = 0;

    // Model state: what the outputs should show after the most recent edge.
    logic [3:0] exp_y   = 4'h0;
    logic       exp_err = 1'b0;
    logic       exp_ov  = 1'b0;
    logic       exp_par = 1'b1;

    always #5 clk = ~clk;

    code_converter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .h         (h),
        .out_valid (out_valid),
        .err       (err)
`ifdef CODE_CONVERTER_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    function automatic logic [3:0] ref_gray(input int n);
        return 4'(n ^ (n >> 1));
    endfunction

    // Gray decode by searching for the binary value whose Gray code matches.
    function automatic logic [3:0] ref_gray2bin(input int gc);
        for (int n = 0; n < 16; n++) begin
            if (int'(ref_gray(n)) == gc) return 4'(n);
        end
        return 4'h0;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [1:0] m, input int x);
        if (r) begin
            exp_y = 4'h0; exp_err = 1'b0; exp_ov = 1'b0; exp_par = 1'b1;
        end else if (v) begin
            exp_ov  = 1'b1;
            exp_err = 1'b0;
            case (m)
                2'd0: exp_y = ref_gray(x);
                2'd1: exp_y = ref_gray2bin(x);
                2'd2: if (x <= 9) exp_y = 4'(x + 3);
                      else begin exp_y = 4'h0; exp_err = 1'b1; end
                default: if (x >= 3 && x <= 12) exp_y = 4'(x - 3);
                         else begin exp_y = 4'h0; exp_err = 1'b1; end
            endcase
            exp_par = ~(^exp_y);
        end else begin
            exp_ov = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare every output against the model.
    task automatic step(input string tag, input logic r, input logic v, input logic [1:0] m, input int x);
        logic [3:0] xv;
        xv = 4'(x);
        @(negedge clk);
        rst = r; in_valid = v; mode = m;
        {a, b, c, d} = xv;
        @(posedge clk);
        model_edge(r, v, m, x);
        #1;
        check({tag, "_y"}, {e, f, g, h}, exp_y);
        check({tag, "_ov"}, 4'(out_valid), 4'(exp_ov));
        check({tag, "_err"}, 4'(err), 4'(exp_err));
`ifdef CODE_CONVERTER_PARITY_EN
        check({tag, "_par"}, 4'(parity), 4'(exp_par));
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; mode = 2'b00; {a, b, c, d} = 4'hF;

        // Reset dominates a valid input
        step("rst0", 1'b1, 1'b1, 2'b00, 15);
        step("rst1", 1'b1, 1'b1, 2'b00, 15);
        check("rst_const_y", {e, f, g, h}, 4'b0000);

        // Binary -> Gray sweep, back-to-back
        for (int i = 0; i < 16; i++) begin
            step("b2g", 1'b0, 1'b1, 2'b00, i);
            if (i == 6)  check("b2g_0110", {e, f, g, h}, 4'b0101);
            if (i == 15) check("b2g_1111", {e, f, g, h}, 4'b1000);
        end

        // Gray -> binary
        step("g2b", 1'b0, 1'b1, 2'b01, 5);
        check("g2b_0101", {e, f, g, h}, 4'b0110);
        step("g2b", 1'b0, 1'b1, 2'b01, 8);
        check("g2b_1000", {e, f, g, h}, 4'b1111);
        for (int i = 0; i < 16; i++) begin
            step("g2b_rt", 1'b0, 1'b1, 2'b01, int'(ref_gray(i)));
            check("g2b_roundtrip", {e, f, g, h}, 4'(i));
        end

        // BCD -> XS3
        step("bcd", 1'b0, 1'b1, 2'b10, 7);
        check("bcd_0111", {e, f, g, h}, 4'b1010);
        step("bcd", 1'b0, 1'b1, 2'b10, 9);
        check("bcd_1001", {e, f, g, h}, 4'b1100);
        step("bcd", 1'b0, 1'b1, 2'b10, 10);
        check("bcd_1010_err", 4'(err), 4'd1);
        step("bcd", 1'b0, 1'b1, 2'b10, 15);
        step("bcd", 1'b0, 1'b1, 2'b10, 0);

        // XS3 -> BCD including range edges
        step("xs3", 1'b0, 1'b1, 2'b11, 12);
        check("xs3_1100", {e, f, g, h}, 4'b1001);
        step("xs3", 1'b0, 1'b1, 2'b11, 3);
        check("xs3_0011_err", 4'(err), 4'd0);
        step("xs3", 1'b0, 1'b1, 2'b11, 2);
        check("xs3_0010_err", 4'(err), 4'd1);
        step("xs3", 1'b0, 1'b1, 2'b11, 13);
        check("xs3_1101_err", 4'(err), 4'd1);
        step("xs3", 1'b0, 1'b1, 2'b11, 0);
        step("xs3", 1'b0, 1'b1, 2'b11, 15);

        // Hold while idle, then reset clears
        step("hold", 1'b0, 1'b1, 2'b00, 6);
        for (int i = 0; i < 3; i++) begin
            step("hold_idle", 1'b0, 1'b0, 2'($urandom_range(3)), int'($urandom_range(15)));
        end
        check("hold_0101", {e, f, g, h}, 4'b0101);
        step("hold_rst", 1'b1, 1'b0, 2'b00, 0);
        step("post_rst", 1'b0, 1'b1, 2'b10, 4);

        // Error flag holds while idle after an illegal code
        step("err_set", 1'b0, 1'b1, 2'b11, 14);
        step("err_hold", 1'b0, 1'b0, 2'b00, 0);

        // Random traffic with mode changes, idles and occasional mid-stream reset
        for (int i = 0; i < 200; i++) begin
            step("rand", ($urandom_range(15) == 0), ($urandom_range(3) != 0),
                 2'($urandom_range(3)), int'($urandom_range(15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/code_converter.md
Name: code_converter

Overview:
- Registered 4-bit code converter, selectable at run time between binary/Gray and BCD/Excess-3 translations.
- Input nibble arrives as four scalar bits a..d. Converted nibble leaves as four scalar bits e..h.
- One-cycle registered datapath with valid and error flags. Used as a leaf utility block feeding display/encoding logic.

Parameters:
- none (all widths fixed at 4 bits; mode selected by port)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  a..d and mode sampled this cycle when high
- mode  input  2  conversion select: 00 bin->Gray, 01 Gray->bin, 10 BCD->XS3, 11 XS3->BCD
- a  input  1  input bit 3 (MSB)
- b  input  1  input bit 2
- c  input  1  input bit 1
- d  input  1  input bit 0 (LSB)
- e  output  1  result bit 3 (MSB)
- f  output  1  result bit 2
- g  output  1  result bit 1
- h  output  1  result bit 0 (LSB)
- out_valid  output  1  high for exactly one cycle per accepted input
- err  output  1  input code illegal for selected mode; qualified by out_valid

Behaviour:
- Interface rule: one clock (clk); reset rst is synchronous and active-high.
- Reset: while rst is high at a rising edge, {e,f,g,h}=0000, out_valid=0, err=0. rst has priority over in_valid.
- Latency: input accepted at edge N (in_valid=1) produces result, out_valid=1 and err after edge N. Outputs are registered; no combinational input-to-output path.
- When in_valid=0 at an edge, out_valid goes 0. {e,f,g,h} and err hold their last values.
- Let X={a,b,c,d} and Y={e,f,g,h}.
- mode 00, bin->Gray: Y = X ^ (X>>1). err=0.
- mode 01, Gray->bin: Y[3]=X[3] and Y[i]=Y[i+1]^X[i] for i=2..0. err=0.
- mode 10, BCD->XS3: if X<=9, Y=X+3 (mod-16 arithmetic never wraps for legal input) and err=0. If X>=10, Y=0000 and err=1.
- mode 11, XS3->BCD: if 3<=X<=12, Y=X-3 and err=0. Otherwise Y=0000 and err=1.
- Back-to-back: in_valid may be high every cycle. Each cycle's input yields its own result one cycle later, so out_valid stays continuously high.
- Mode may change on any cycle. The conversion uses the mode sampled with the same input; there is no pipeline mixing.
- Reset mid-stream: the pending result is discarded. The first valid input after rst deasserts behaves normally.

Optional Feature:
- Macro CODE_CONVERTER_PARITY_EN.
- When defined: adds output port parity (1 bit), registered alongside Y. parity = odd parity of Y (XOR of e,f,g,h inverted), so {Y,parity} always has an odd count of ones. Reset value 1. Holds when in_valid=0.
- When undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package code_converter_pkg: mode localparams MODE_BIN2GRAY=2'b00, MODE_GRAY2BIN=2'b01, MODE_BCD2XS3=2'b10, MODE_XS32BCD=2'b11; constants XS3_OFFSET=4'd3, BCD_MAX=4'd9, XS3_MIN=4'd3, XS3_MAX=4'd12.
- One natural sub-module code_converter_core: purely combinational (X, mode) -> (Y, err). Top holds the registers, valid and reset.

Test Plan:
- Reset with rst=1 for 2 cycles while in_valid=1, X=1111 -> Y=0000, out_valid=0, err=0 throughout.
- mode 00, sweep X=0000..1111 every cycle -> Y equals the Gray code one cycle later (e.g. 0110->0101, 1111->1000), out_valid continuously 1, err=0.
- mode 01, X=0101 -> Y=0110; X=1000 -> Y=1111; round-trip all 16 Gray codes back to binary.
- mode 10, X=0111 -> Y=1010, err=0; X=1001 -> Y=1100; X=1010 -> Y=0000, err=1.
- mode 11, X=1100 -> Y=1001, err=0; X=0011 -> Y=0000, err=0; X=0010 and X=1101 -> Y=0000, err=1.
- in_valid=1 with X=0110 (mode 00), then in_valid=0 for 3 cycles -> out_valid drops to 0 and Y holds 0101. Then assert rst for 1 cycle -> Y=0000. With CODE_CONVERTER_PARITY_EN, parity=1 after reset and parity=1 for Y=0101.
